// File: rtl/tile_writer.sv
// ============================================================================
// Module      : tile_writer
// Description : Write-side engine for the tile map and tile store memories.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_writer #(
    parameter int MAP_W = 80,
    parameter int MAP_H = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [6:0]  cmd_x,
    input  logic [5:0]  cmd_y,
    input  logic [5:0]  cmd_tile,
    input  logic [23:0] cmd_color,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [23:0] pix_data,
    input  logic        wr_en,
    output logic [6:0]  tm_write_x,
    output logic [5:0]  tm_write_y,
    output logic [5:0]  tm_v,
    output logic        tm_w,
    output logic [2:0]  t_write_x,
    output logic [2:0]  t_write_y,
    output logic [5:0]  t_write_adr,
    output logic [23:0] t_v,
    output logic        t_w,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_fill = 2'd1;
    localparam logic [1:0] c_st_load = 2'd2;

    localparam logic [1:0] c_op_map_write  = 2'd0;
    localparam logic [1:0] c_op_map_fill   = 2'd1;
    localparam logic [1:0] c_op_tile_load  = 2'd2;

    localparam logic [7:0] c_map_w  = 8'(MAP_W);
    localparam logic [6:0] c_map_h  = 7'(MAP_H);
    localparam logic [6:0] c_last_x = 7'(MAP_W - 1);
    localparam logic [5:0] c_last_y = 6'(MAP_H - 1);

    logic [1:0]  r_state, w_state_nxt;
    logic [6:0]  r_fill_x, w_fill_x_nxt;
    logic [5:0]  r_fill_y, w_fill_y_nxt;
    logic [5:0]  r_fill_val, w_fill_val_nxt;
    logic        r_fill_fin, w_fill_fin_nxt;
    logic [5:0]  r_pix_cnt, w_pix_cnt_nxt;
    logic [5:0]  r_load_adr, w_load_adr_nxt;

    logic [6:0]  w_tm_x_nxt;
    logic [5:0]  w_tm_y_nxt;
    logic [5:0]  w_tm_v_nxt;
    logic        w_tm_w_nxt;
    logic [2:0]  w_t_x_nxt;
    logic [2:0]  w_t_y_nxt;
    logic [5:0]  w_t_adr_nxt;
    logic [23:0] w_t_v_nxt;
    logic        w_t_w_nxt;
    logic        w_done_nxt;
    logic        w_err_nxt;
    logic        w_fill_go;

    logic        w_cmd_fire;
    logic        w_pix_fire;
    logic        w_cmd_in_range;
    logic [6:0]  w_fx;
    logic [5:0]  w_fy;

    assign cmd_ready      = rst_n && (r_state == c_st_idle) && wr_en;
    assign pix_ready      = rst_n && (r_state == c_st_load) && wr_en;
    assign busy           = (r_state != c_st_idle);
    assign w_cmd_fire     = cmd_valid && cmd_ready;
    assign w_pix_fire     = pix_valid && pix_ready;
    assign w_cmd_in_range = ({1'b0, cmd_x} < c_map_w) && ({1'b0, cmd_y} < c_map_h);

    // The accept cycle issues the first fill write, so the raster starts at (0,0) there.
    assign w_fx = (r_state == c_st_fill) ? r_fill_x : 7'd0;
    assign w_fy = (r_state == c_st_fill) ? r_fill_y : 6'd0;

    always_comb begin
        w_state_nxt    = r_state;
        w_fill_x_nxt   = r_fill_x;
        w_fill_y_nxt   = r_fill_y;
        w_fill_val_nxt = r_fill_val;
        w_fill_fin_nxt = r_fill_fin;
        w_pix_cnt_nxt  = r_pix_cnt;
        w_load_adr_nxt = r_load_adr;
        w_tm_x_nxt     = tm_write_x;
        w_tm_y_nxt     = tm_write_y;
        w_tm_v_nxt     = tm_v;
        w_tm_w_nxt     = 1'b0;
        w_t_x_nxt      = t_write_x;
        w_t_y_nxt      = t_write_y;
        w_t_adr_nxt    = t_write_adr;
        w_t_v_nxt      = t_v;
        w_t_w_nxt      = 1'b0;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_fill_go      = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (w_cmd_fire) begin
                    case (cmd_op)
                        c_op_map_write: begin
                            w_done_nxt = 1'b1;
                            if (w_cmd_in_range) begin
                                w_tm_w_nxt = 1'b1;
                                w_tm_x_nxt = cmd_x;
                                w_tm_y_nxt = cmd_y;
                                w_tm_v_nxt = cmd_tile;
                            end else begin
                                w_err_nxt = 1'b1;
                            end
                        end
                        c_op_map_fill: begin
                            w_fill_val_nxt = cmd_tile;
                            w_fill_fin_nxt = 1'b0;
                            w_fill_go      = 1'b1;
                            w_state_nxt    = c_st_fill;
                        end
                        c_op_tile_load: begin
                            w_pix_cnt_nxt  = 6'd0;
                            w_load_adr_nxt = cmd_tile;
                            w_state_nxt    = c_st_load;
                        end
                        default: begin
                            w_t_w_nxt   = 1'b1;
                            w_t_x_nxt   = cmd_x[2:0];
                            w_t_y_nxt   = cmd_y[2:0];
                            w_t_adr_nxt = cmd_tile;
                            w_t_v_nxt   = cmd_color;
                            w_done_nxt  = 1'b1;
                        end
                    endcase
                end
            end
            c_st_fill: begin
                // Hold FILL for the cycle that presents done, then release.
                if (r_fill_fin) begin
                    w_state_nxt = c_st_idle;
                end else if (wr_en) begin
                    w_fill_go = 1'b1;
                end
            end
            c_st_load: begin
                if (w_pix_fire) begin
                    w_t_w_nxt     = 1'b1;
                    w_t_x_nxt     = r_pix_cnt[2:0];
                    w_t_y_nxt     = r_pix_cnt[5:3];
                    w_t_adr_nxt   = r_load_adr;
                    w_t_v_nxt     = pix_data;
                    w_pix_cnt_nxt = r_pix_cnt + 6'd1;
                    if (r_pix_cnt == 6'd63) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = c_st_idle;
                    end
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase

        if (w_fill_go) begin
            w_tm_w_nxt = 1'b1;
            w_tm_x_nxt = w_fx;
            w_tm_y_nxt = w_fy;
            w_tm_v_nxt = (r_state == c_st_idle) ? cmd_tile : r_fill_val;
            if (w_fx == c_last_x) begin
                w_fill_x_nxt = 7'd0;
                if (w_fy == c_last_y) begin
                    w_fill_y_nxt   = 6'd0;
                    w_fill_fin_nxt = 1'b1;
                    w_done_nxt     = 1'b1;
                end else begin
                    w_fill_y_nxt = w_fy + 6'd1;
                end
            end else begin
                w_fill_x_nxt = w_fx + 7'd1;
                w_fill_y_nxt = w_fy;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_fill_x    <= 7'd0;
            r_fill_y    <= 6'd0;
            r_fill_val  <= 6'd0;
            r_fill_fin  <= 1'b0;
            r_pix_cnt   <= 6'd0;
            r_load_adr  <= 6'd0;
            tm_write_x  <= 7'd0;
            tm_write_y  <= 6'd0;
            tm_v        <= 6'd0;
            tm_w        <= 1'b0;
            t_write_x   <= 3'd0;
            t_write_y   <= 3'd0;
            t_write_adr <= 6'd0;
            t_v         <= 24'd0;
            t_w         <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fill_x    <= w_fill_x_nxt;
            r_fill_y    <= w_fill_y_nxt;
            r_fill_val  <= w_fill_val_nxt;
            r_fill_fin  <= w_fill_fin_nxt;
            r_pix_cnt   <= w_pix_cnt_nxt;
            r_load_adr  <= w_load_adr_nxt;
            tm_write_x  <= w_tm_x_nxt;
            tm_write_y  <= w_tm_y_nxt;
            tm_v        <= w_tm_v_nxt;
            tm_w        <= w_tm_w_nxt;
            t_write_x   <= w_t_x_nxt;
            t_write_y   <= w_t_y_nxt;
            t_write_adr <= w_t_adr_nxt;
            t_v         <= w_t_v_nxt;
            t_w         <= w_t_w_nxt;
            done        <= w_done_nxt;
            err         <= w_err_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tile_writer.sv
// ============================================================================
// Module      : tb_tile_writer
// Description : Directed self-checking bench for tile_writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tile_writer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [6:0]  cmd_x;
    logic [5:0]  cmd_y;
    logic [5:0]  cmd_tile;
    logic [23:0] cmd_color;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_data;
    logic        wr_en;
    logic [6:0]  tm_write_x;
    logic [5:0]  tm_write_y;
    logic [5:0]  tm_v;
    logic        tm_w;
    logic [2:0]  t_write_x;
    logic [2:0]  t_write_y;
    logic [5:0]  t_write_adr;
    logic [23:0] t_v;
    logic        t_w;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    tile_writer #(.MAP_W(80), .MAP_H(60)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_tile    (cmd_tile),
        .cmd_color   (cmd_color),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .wr_en       (wr_en),
        .tm_write_x  (tm_write_x),
        .tm_write_y  (tm_write_y),
        .tm_v        (tm_v),
        .tm_w        (tm_w),
        .t_write_x   (t_write_x),
        .t_write_y   (t_write_y),
        .t_write_adr (t_write_adr),
        .t_v         (t_v),
        .t_w         (t_w),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic a_tm_w, input logic [6:0] a_tx,
                                       input logic [5:0] a_ty, input logic [5:0] a_tv,
                                       input logic a_t_w, input logic [2:0] a_px,
                                       input logic [2:0] a_py, input logic [5:0] a_adr,
                                       input logic [23:0] a_pv, input logic a_done,
                                       input logic a_err, input logic a_busy);
        return {4'd0, a_tm_w, a_tx, a_ty, a_tv, a_t_w, a_px, a_py, a_adr, a_pv,
                a_done, a_err, a_busy};
    endfunction

    function automatic logic [63:0] out_vec();
        return mk(tm_w, tm_write_x, tm_write_y, tm_v, t_w, t_write_x, t_write_y,
                  t_write_adr, t_v, done, err, busy);
    endfunction

    // Presents a command at the current negedge and returns at the negedge after acceptance.
    task automatic send_cmd(input logic [1:0] op, input logic [6:0] x, input logic [5:0] y,
                            input logic [5:0] tile, input logic [23:0] color, output int waits);
        cmd_op = op; cmd_x = x; cmd_y = y; cmd_tile = tile; cmd_color = color;
        cmd_valid = 1'b1;
        waits = 0;
        #1;
        while (cmd_ready !== 1'b1 && waits < 50) begin
            @(negedge clk); #1;
            waits++;
        end
        if (cmd_ready !== 1'b1) check("cmd_accept_timeout", {63'd0, cmd_ready}, 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_fill(input string tag, input logic [5:0] tile, input bit toggle);
        int k, writes, bad, done_k, ex, ey, waits;
        logic prev;
        send_cmd(2'd1, 7'd0, 6'd0, tile, 24'd0, waits);
        k = 1; writes = 0; bad = 0; done_k = 0; ex = 0; ey = 0; prev = 1'b1;
        while (done_k == 0 && k < 12000) begin
            if (tm_w !== prev) bad++;
            if (tm_w === 1'b1) begin
                if ({tm_write_x, tm_write_y, tm_v} !== {7'(ex), 6'(ey), tile} || t_w !== 1'b0) bad++;
                writes++;
                ex++;
                if (ex == 80) begin ex = 0; ey++; end
            end
            if (done === 1'b1) begin
                done_k = k;
            end else begin
                if (toggle) wr_en = ((k / 4) % 2 == 0);
                prev = wr_en;
                @(negedge clk);
                k++;
            end
        end
        wr_en = 1'b1;
        check({tag, "_done_seen"}, {63'd0, done_k != 0}, 64'd1);
        check({tag, "_writes"}, 64'(writes), 64'd4800);
        check({tag, "_order_and_strobe"}, 64'(bad), 64'd0);
        check({tag, "_last_xy"}, {51'd0, tm_write_x, tm_write_y}, {51'd0, 7'd79, 6'd59});
        if (!toggle) check({tag, "_done_cycle"}, 64'(done_k), 64'd4800);
        @(negedge clk); #1;
        check({tag, "_idle_after"}, {62'd0, busy, cmd_ready}, {62'd0, 1'b0, 1'b1});
    endtask

    initial begin
        int waits, bad, writes, j;
        rst_n = 1'b0; wr_en = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_x = 7'd0;
        cmd_y = 6'd0; cmd_tile = 6'd0; cmd_color = 24'd0; pix_valid = 1'b0; pix_data = 24'd0;
        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), 64'd0);
        check("reset_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", {62'd0, cmd_ready, pix_ready}, {62'd0, 1'b1, 1'b0});
        @(negedge clk);

        // Single in-range map write.
        send_cmd(2'd0, 7'd5, 6'd3, 6'd17, 24'd0, waits);
        check("map_write", out_vec(), mk(1, 5, 3, 17, 0, 0, 0, 0, 0, 1, 0, 0));
        @(negedge clk);
        check("map_write_after", out_vec(), mk(0, 5, 3, 17, 0, 0, 0, 0, 0, 0, 0, 0));

        // Out-of-range map writes at each bound.
        send_cmd(2'd0, 7'd80, 6'd0, 6'd2, 24'd0, waits);
        check("map_write_x_oob", out_vec(), mk(0, 5, 3, 17, 0, 0, 0, 0, 0, 1, 1, 0));
        @(negedge clk);
        send_cmd(2'd0, 7'd0, 6'd60, 6'd2, 24'd0, waits);
        check("map_write_y_oob", out_vec(), mk(0, 5, 3, 17, 0, 0, 0, 0, 0, 1, 1, 0));
        send_cmd(2'd0, 7'd79, 6'd59, 6'd63, 24'd0, waits);
        check("map_write_corner", out_vec(), mk(1, 79, 59, 63, 0, 0, 0, 0, 0, 1, 0, 0));

        run_fill("fill", 6'd9, 1'b0);
        run_fill("fill_toggle", 6'd9, 1'b1);

        // Streamed tile load with gaps.
        send_cmd(2'd2, 7'd0, 6'd0, 6'd42, 24'd0, waits);
        check("load_busy", {63'd0, busy}, 64'd1);
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            pix_valid = 1'b1;
            pix_data  = 24'(k);
            j = 0;
            #1;
            while (pix_ready !== 1'b1 && j < 50) begin @(negedge clk); #1; j++; end
            if (pix_ready !== 1'b1) bad++;
            @(negedge clk);
            pix_valid = 1'b0;
            if ({t_w, t_write_x, t_write_y, t_write_adr, t_v, done, tm_w} !==
                {1'b1, 3'(k % 8), 3'(k / 8), 6'd42, 24'(k), k == 63, 1'b0}) bad++;
            if (k % 5 == 4 && k != 63) begin
                @(negedge clk);
                if (t_w !== 1'b0 || done !== 1'b0) bad++;
            end
        end
        check("load_pixels", 64'(bad), 64'd0);
        check("load_last", out_vec(), mk(0, 79, 59, 9, 1, 7, 7, 42, 24'h00003F, 1, 0, 0));

        // Pixel stream ignored while idle.
        pix_valid = 1'b1;
        #1;
        check("pix_ready_idle", {63'd0, pix_ready}, 64'd0);
        @(negedge clk);
        check("pix_ignored_idle", {62'd0, t_w, done}, 64'd0);
        pix_valid = 1'b0;

        send_cmd(2'd3, 7'd7, 6'd7, 6'd1, 24'hFF8000, waits);
        check("tile_pixel", out_vec(), mk(0, 79, 59, 9, 1, 7, 7, 1, 24'hFF8000, 1, 0, 0));
        @(negedge clk);

        // Reset in the middle of a fill.
        send_cmd(2'd1, 7'd0, 6'd0, 6'd4, 24'd0, waits);
        writes = 0; j = 0;
        while (j < 500) begin
            if (tm_w === 1'b1) writes++;
            if (writes == 100) break;
            @(negedge clk);
            j++;
        end
        check("fill_100_writes", 64'(writes), 64'd100);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_fill_reset", out_vec(), 64'd0);
        rst_n = 1'b1;
        send_cmd(2'd0, 7'd10, 6'd20, 6'd33, 24'd0, waits);
        check("accept_after_reset", 64'(waits), 64'd0);
        check("map_write_after_reset", out_vec(), mk(1, 10, 20, 33, 0, 0, 0, 0, 0, 1, 0, 0));
        @(negedge clk);
        check("no_stray_fill", {63'd0, tm_w}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
